clock_gate_mc: RTL

//  Multi-channel clock gate controller for the matrix datapath. Each of NCH

---
 rtl/clock_gate_mc.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/clock_gate_mc.sv
// -----------------------------------------------------------------------------
// clock_gate_mc
//
// Multi-channel clock gate controller. Each channel runs a small FSM
// (OFF -> WAKE -> ON -> DRAIN -> OFF) driven by level wake/shutdown requests.
// It produces a glitch-free latch-gated clock, a registered active flag and a
// one-cycle start pulse per wake-up.
//
// Optional feature macro: CLOCK_GATE_IDLE_TIMEOUT_EN
//   When defined, a per-channel idle counter auto-drains an ON channel after
//   idle_limit consecutive non-busy cycles. When undefined, busy and
//   idle_limit are accepted but ignored.
//
// Parameters
//   NCH        number of gated channels
//   DRAIN_CYC  cycles the clock keeps running after clk_end (>= 1)
//   IDLE_W     width of idle_limit and the idle counters
//
// Ports
//   clk_i       in   1       free-running clock
//   rst         in   1       synchronous active-low reset
//   clk_en      in   NCH     per-channel wake request (level)
//   clk_end     in   NCH     per-channel shutdown request (level)
//   busy        in   NCH     per-channel activity flag (idle timeout only)
//   idle_limit  in   IDLE_W  idle cycles before auto-shutdown, 0 disables
//   clk_o       out  NCH     gated clocks
//   rst_o       out  NCH     channel active (state != OFF), registered
//   start_in    out  NCH     one-cycle start pulse per wake-up, registered
//   all_off     out  1       every channel OFF, registered
// -----------------------------------------------------------------------------
module clock_gate_mc #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned DRAIN_CYC = 2,
    parameter int unsigned IDLE_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic [NCH-1:0]    clk_en,
    input  logic [NCH-1:0]    clk_end,
    input  logic [NCH-1:0]    busy,
    input  logic [IDLE_W-1:0] idle_limit,
    output logic [NCH-1:0]    clk_o,
    output logic [NCH-1:0]    rst_o,
    output logic [NCH-1:0]    start_in,
    output logic              all_off
);

    localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0] DrainLoad = DCW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StWake  = 2'd1,
        StOn    = 2'd2,
        StDrain = 2'd3
    } state_e;

    state_e         r_state     [NCH];
    logic [DCW-1:0] r_drain_cnt [NCH];
    logic [NCH-1:0] r_active;
    logic [NCH-1:0] r_start;
    logic           r_all_off;
    logic [NCH-1:0] r_en_latch;

    state_e         w_state_nxt [NCH];
    logic [DCW-1:0] w_cnt_nxt   [NCH];
    logic [NCH-1:0] w_idle_hit;
    logic [NCH-1:0] w_active_nxt;
    logic [NCH-1:0] w_start_nxt;

`ifdef CLOCK_GATE_IDLE_TIMEOUT_EN
    logic [IDLE_W-1:0] r_idle [NCH];

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_idle_hit[c] = (idle_limit != '0) && (r_idle[c] == idle_limit);
        end
    end

    // Counter is held at zero outside ON, so every entry to ON starts fresh.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NCH; c++) begin
            if (!rst || r_state[c] != StOn || busy[c]) begin
                r_idle[c] <= '0;
            end else if (r_idle[c] != {IDLE_W{1'b1}}) begin
                r_idle[c] <= r_idle[c] + 1'b1;
            end
        end
    end
`else
    logic w_unused;
    assign w_unused   = ^{busy, idle_limit};
    assign w_idle_hit = '0;
`endif

    // Next-state logic; clk_en always takes priority over any shutdown cause.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_state_nxt[c] = r_state[c];
            w_cnt_nxt[c]   = r_drain_cnt[c];
            unique case (r_state[c])
                StOff: begin
                    if (clk_en[c]) w_state_nxt[c] = StWake;
                end
                StWake: begin
                    if (clk_end[c] && !clk_en[c]) begin
                        w_state_nxt[c] = StDrain;
                        w_cnt_nxt[c]   = DrainLoad;
                    end else begin
                        w_state_nxt[c] = StOn;
                    end
                end
                StOn: begin
                    if (!clk_en[c] && (clk_end[c] || w_idle_hit[c])) begin
                        w_state_nxt[c] = StDrain;
                        w_cnt_nxt[c]   = DrainLoad;
                    end
                end
                StDrain: begin
                    if (clk_en[c]) begin
                        w_state_nxt[c] = StOn;
                    end else if (r_drain_cnt[c] == '0) begin
                        w_state_nxt[c] = StOff;
                    end else begin
                        w_cnt_nxt[c] = r_drain_cnt[c] - 1'b1;
                    end
                end
                default: w_state_nxt[c] = StOff;
            endcase
            w_active_nxt[c] = (w_state_nxt[c] != StOff);
            w_start_nxt[c]  = (w_state_nxt[c] == StWake);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                r_state[c]     <= StOff;
                r_drain_cnt[c] <= '0;
            end
            r_active  <= '0;
            r_start   <= '0;
            r_all_off <= 1'b1;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                r_state[c]     <= w_state_nxt[c];
                r_drain_cnt[c] <= w_cnt_nxt[c];
            end
            r_active  <= w_active_nxt;
            r_start   <= w_start_nxt;
            r_all_off <= ~|w_active_nxt;
        end
    end

    // Enable latch is transparent only while clk_i is low, so the AND gate
    // below can never produce a runt or glitch on clk_o.
    always_latch begin
        if (!clk_i) r_en_latch = r_active;
    end

    assign clk_o    = {NCH{clk_i}} & r_en_latch;
    assign rst_o    = r_active;
    assign start_in = r_start;
    assign all_off  = r_all_off;

endmodule
